fb_access_scheduler: RTL and testbench
======================================

# fb_access_scheduler

Arbitrates the single-port spectrum frame-buffer RAM between the HDMI scanout reader and the FFT column writer. Scanout reads have strict priority and fixed latency, so the display never sees a stall. Writer traffic goes through a small posted-write queue and drains in cycles the scanout leaves free, mostly horizontal and vertical blanking. The block sits between the video timing/pixel pipeline, the FFT result formatter and the frame-buffer RAM.

## Interface

- ADDR_W, 15, frame-buffer address width
- DATA_W, 8, pixel/data width
- WQ_DEPTH, 4, posted-write queue depth (power of 2, ≥2)
- STARVE_LIMIT, 1024, consecutive full-and-blocked cycles before wr_starved sets

- clk_25m  in  1  pixel clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- vid_req  in  1  scanout read request this cycle
- vid_addr  in  ADDR_W  scanout read address
- vid_rdata  out  DATA_W  read data
- vid_rvalid  out  1  vid_rdata valid
- wr_valid  in  1  writer offers a word
- wr_ready  out  1  queue accepts a word
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, synchronous, valid the cycle after mem_en && !mem_we
- wq_level  out  $clog2(WQ_DEPTH)+1  queue occupancy
- wr_starved  out  1  sticky starvation flag

## Operation

- Write queue: circular FIFO with WQ_DEPTH entries holding {addr, data}.
  - Push when wr_valid && wr_ready.
  - Pop when a write is granted.
- wr_ready is registered. It is 1 exactly when the next-cycle occupancy is < WQ_DEPTH.
  - A full queue never accepts a word, even in a cycle where it pops.
  - A push and a pop in the same cycle leave occupancy unchanged.
- Arbitration is evaluated each cycle in this order:
  1. vid_req=1: grant READ at vid_addr.
  2. Otherwise, queue not empty: grant WRITE of the head entry and pop it.
  3. Otherwise: IDLE.
- Scanout never waits. The grant is unconditional for vid_req.
- No read/write forwarding. A scanout read returns the RAM contents, even when a write to the same address is still queued.
- Write ordering is strictly FIFO.
- Starvation detection:
  - An internal counter increments each cycle that the queue is full and vid_req=1.
  - Any cycle that is not both full and blocked clears the counter.
  - When the counter reaches STARVE_LIMIT, wr_starved sets and stays set until rst.
  - The counter saturates.
- Writer data is never dropped. Backpressure is via wr_ready only.

## Timing

- Grant decided in cycle N. mem_en/mem_we/mem_addr/mem_wdata are registered and present in N+1.
- RAM returns mem_rdata in N+2. vid_rdata/vid_rvalid are registered in N+3.
- Scanout read latency is therefore exactly 3 cycles.
- Back-to-back vid_req gives one vid_rvalid per cycle with no bubbles.
- IDLE cycle: mem_en=0, mem_we=0. mem_addr/mem_wdata hold their last values.
- WRITE cycle: mem_en=1, mem_we=1.
- vid_rvalid=1 only for cycles that carry READ data.
- wq_level is registered and reflects occupancy after the edge's push/pop.
- Reset while rst=1, asynchronous:
  - Every output is 0, including wr_ready.
  - Queue is empty.
  - In-flight reads are discarded, and no vid_rvalid appears for them after release.
- After release, wr_ready rises on the first clock edge.
- rst asserted mid-burst discards queued writes. The writer must re-send them.

## Test plan

- **Reset:** hold rst 5 cycles mid-traffic, then release.
  - While rst=1, all outputs are 0.
  - wr_ready=1 one edge after release.
  - No stray vid_rvalid.
- **Read latency:** vid_req for 8 consecutive cycles at addresses 0x0100–0x0107, with RAM model data = addr[7:0].
  - vid_rvalid high for 8 cycles, starting 3 cycles after the first request.
  - vid_rdata 0x00–0x07 in order.
- **Queue fill and drain:** vid_req=1 constantly, then push 5 words.
  - 4 words accepted, wr_ready=0, wq_level=4.
  - Drop vid_req: 4 writes appear on consecutive cycles in push order.
  - wr_ready returns, and the 5th word is accepted.
- **Priority:** queue holds 2 writes, then vid_req pulses 1,0,1,0.
  - mem port sequence is READ, WRITE, READ, WRITE.
  - wq_level ends at 0.
- **Starvation:** queue full, vid_req held high for STARVE_LIMIT cycles (default 1024).
  - wr_starved=0 at cycle 1023 and 1 at cycle 1024.
  - After vid_req drops it remains 1; only rst clears it.
- **Simultaneous push/pop at occupancy 2 with vid_req=0:** wq_level stays 2 and the writes retire in FIFO order.

Source files
------------

// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler: shares the single-port frame-buffer RAM between scanout reads and posted FFT writes
// Ports:
//   clk_25m, rst                         pixel clock, async active-high reset
//   vid_req/vid_addr -> vid_rdata/rvalid  scanout reads, fixed 3-cycle latency, strict priority
//   wr_valid/wr_ready/wr_addr/wr_data     writer words into the posted-write queue
//   mem_en/mem_we/mem_addr/mem_wdata      registered RAM port; mem_rdata returns one cycle after a read
//   wq_level, wr_starved                  queue occupancy and sticky starvation flag
module fb_access_scheduler #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int WQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                         clk_25m,
  input  logic                         rst,
  input  logic                         vid_req,
  input  logic [ADDR_W-1:0]            vid_addr,
  output logic [DATA_W-1:0]            vid_rdata,
  output logic                         vid_rvalid,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(WQ_DEPTH):0]    wq_level,
  output logic                         wr_starved
);
  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  logic [ADDR_W-1:0] r_q_addr [WQ_DEPTH];
  logic [DATA_W-1:0] r_q_data [WQ_DEPTH];
  logic [PTR_W-1:0]  r_wp, r_rp;
  logic [LVL_W-1:0]  r_level;
  logic              r_wr_ready;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rd_p1, r_rd_p2;
  logic              r_vid_rvalid;
  logic [DATA_W-1:0] r_vid_rdata;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_starved;
  logic              w_full, w_empty, w_push, w_pop, w_blocked;
  logic [LVL_W-1:0]  w_level_nxt;
  logic [SC_W-1:0]   w_starve_nxt;
  assign w_full       = r_level == LVL_W'(WQ_DEPTH);
  assign w_empty      = r_level == '0;
  // wr_ready is already low when full, so a full queue never pushes even while it pops
  assign w_push       = wr_valid && r_wr_ready;
  assign w_pop        = !vid_req && !w_empty;
  assign w_level_nxt  = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_blocked    = w_full && vid_req;
  assign w_starve_nxt = !w_blocked ? '0
                      : (r_starve_cnt == SC_W'(STARVE_LIMIT)) ? r_starve_cnt
                      : r_starve_cnt + 1'b1;
  // queue storage needs no reset: pointers and level define what is valid
  always_ff @(posedge clk_25m) begin
    if (w_push) begin
      r_q_addr[r_wp] <= wr_addr;
      r_q_data[r_wp] <= wr_data;
    end
  end
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_level      <= '0;
      r_wr_ready   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rd_p1      <= 1'b0;
      r_rd_p2      <= 1'b0;
      r_vid_rvalid <= 1'b0;
      r_vid_rdata  <= '0;
      r_starve_cnt <= '0;
      r_starved    <= 1'b0;
    end else begin
      r_level    <= w_level_nxt;
      r_wr_ready <= w_level_nxt < LVL_W'(WQ_DEPTH);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_mem_en <= vid_req || w_pop;
      r_mem_we <= w_pop;
      if (vid_req) r_mem_addr <= vid_addr;
      else if (w_pop) begin
        r_mem_addr  <= r_q_addr[r_rp];
        r_mem_wdata <= r_q_data[r_rp];
      end
      // read tag follows the access: RAM port stage, RAM data stage, output register
      r_rd_p1      <= vid_req;
      r_rd_p2      <= r_rd_p1;
      r_vid_rvalid <= r_rd_p2;
      if (r_rd_p2) r_vid_rdata <= mem_rdata;
      r_starve_cnt <= w_starve_nxt;
      if (w_starve_nxt == SC_W'(STARVE_LIMIT)) r_starved <= 1'b1;
    end
  end
  assign vid_rdata  = r_vid_rdata;
  assign vid_rvalid = r_vid_rvalid;
  assign wr_ready   = r_wr_ready;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign wq_level   = r_level;
  assign wr_starved = r_starved;
endmodule

// File: tb/tb_fb_access_scheduler.sv
// tb_fb_access_scheduler: directed and randomized checks of fb_access_scheduler against a queue-based model
module tb_fb_access_scheduler;
  localparam int DEPTH = 4;
  localparam int LIMIT = 1024;
  logic        clk_25m, rst, vid_req, wr_valid;
  logic [14:0] vid_addr, wr_addr, mem_addr;
  logic [7:0]  wr_data, vid_rdata, mem_wdata, mem_rdata;
  logic        vid_rvalid, wr_ready, mem_en, mem_we, wr_starved;
  logic [2:0]  wq_level;
  int total = 0;
  int bad = 0;
  fb_access_scheduler dut (
    .clk_25m(clk_25m), .rst(rst), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wq_level(wq_level), .wr_starved(wr_starved)
  );
  initial clk_25m = 1'b0;
  always #5 clk_25m = ~clk_25m;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // frame-buffer RAM: contents start as addr[7:0], synchronous read
  logic [7:0] ram [0:32767];
  initial begin
    for (int a = 0; a < 32768; a++) ram[a] = 8'(a);
    mem_rdata = '0;
    forever begin
      @(posedge clk_25m);
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      else if (mem_en) mem_rdata <= ram[mem_addr];
    end
  end
  // behavioural model: pending writes as a queue, RAM image updated when a write actually lands
  typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
  typedef struct { int due; logic [7:0] d; } rd_t;
  wr_t q[$];
  rd_t rdq[$];
  logic [7:0]  mram [0:32767];
  int          cyc = 0;
  int          scnt = 0;
  bit          m_live = 0;
  bit          m_wr_ready, m_en, m_we, m_rvalid, m_starved, pend_w;
  logic [14:0] m_addr, pend_a;
  logic [7:0]  m_wdata, m_rdata, pend_d;
  task automatic model_step();
    bit full, push;
    wr_t w;
    rd_t r;
    cyc++;
    if (rst) begin
      q.delete();
      rdq.delete();
      {m_wr_ready, m_en, m_we, m_rvalid, m_starved, pend_w} = '0;
      m_addr = '0;
      m_wdata = '0;
      scnt = 0;
      m_live = 1;
      return;
    end
    // a write granted last cycle reaches the RAM at this edge
    if (pend_w) mram[pend_a] = pend_d;
    pend_w = 0;
    full = q.size() == DEPTH;
    push = wr_valid && m_wr_ready;
    if (vid_req) begin
      m_en = 1;
      m_we = 0;
      m_addr = vid_addr;
      r.due = cyc + 2;
      r.d = mram[vid_addr];
      rdq.push_back(r);
    end else if (q.size() > 0) begin
      w = q.pop_front();
      m_en = 1;
      m_we = 1;
      m_addr = w.a;
      m_wdata = w.d;
      pend_w = 1;
      pend_a = w.a;
      pend_d = w.d;
    end else begin
      m_en = 0;
      m_we = 0;
    end
    if (push) begin
      w.a = wr_addr;
      w.d = wr_data;
      q.push_back(w);
    end
    m_wr_ready = q.size() < DEPTH;
    scnt = (full && vid_req) ? ((scnt < LIMIT) ? scnt + 1 : scnt) : 0;
    if (scnt == LIMIT) m_starved = 1;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      m_rvalid = 1;
      m_rdata = rdq[0].d;
      void'(rdq.pop_front());
    end else m_rvalid = 0;
  endtask
  initial begin
    for (int a = 0; a < 32768; a++) mram[a] = 8'(a);
    forever begin
      @(posedge clk_25m);
      model_step();
    end
  end
  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk_25m);
    if (rst)
      chk("rst_zero", {vid_rdata, vid_rvalid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata, wq_level, wr_starved}, '0);
    else if (m_live) begin
      chk("wr_ready", wr_ready, m_wr_ready);
      chk("wq_level", wq_level, q.size());
      chk("vid_rvalid", vid_rvalid, m_rvalid);
      if (m_rvalid) chk("vid_rdata", vid_rdata, m_rdata);
      chk("mem_en", mem_en, m_en);
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("wr_starved", wr_starved, m_starved);
    end
  end
  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask
  initial begin
    rst = 0; vid_req = 0; vid_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    #2 rst = 1;
    repeat (3) step();
    @(negedge clk_25m);
    chk("rst_level", wq_level, 0);
    step();
    rst = 0;
    @(negedge clk_25m);
    chk("rel_ready_pre", wr_ready, 0);
    step();
    @(negedge clk_25m);
    chk("rel_ready", wr_ready, 1);
    // read latency: 8 back-to-back reads at 0x100..0x107
    for (int j = 0; j < 13; j++) begin
      step();
      vid_req = j < 8;
      vid_addr = 15'(256 + j);
      @(negedge clk_25m);
      chk("lat_rvalid", vid_rvalid, j >= 3 && j < 11);
      if (j >= 3 && j < 11) chk("lat_rdata", vid_rdata, j - 3);
    end
    // fill under constant scanout, then drain in push order
    for (int k = 0; k < 4; k++) begin
      step();
      vid_req = 1; vid_addr = 15'($urandom_range(0, 31));
      wr_valid = 1; wr_addr = 15'(16'h2000 + k); wr_data = 8'(8'hA0 + k);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vid_addr = 15'($urandom_range(0, 31));
      wr_addr = 15'h2004; wr_data = 8'hA4;
      @(negedge clk_25m);
      if (k == 2) begin
        chk("fill_level", wq_level, 4);
        chk("fill_ready", wr_ready, 0);
      end
    end
    for (int j = 0; j < 8; j++) begin
      step();
      vid_req = 0;
      wr_valid = j <= 1;
      @(negedge clk_25m);
      if (j >= 1 && j <= 5) begin
        chk("drain_we", mem_we, 1);
        chk("drain_addr", mem_addr, 16'h2000 + j - 1);
        chk("drain_data", mem_wdata, 8'hA0 + j - 1);
      end
      if (j == 1) chk("drain_ready", wr_ready, 1);
      if (j == 2) chk("drain_level", wq_level, 3);
      if (j == 6) chk("drain_empty", wq_level, 0);
    end
    // priority: two queued writes interleave with read pulses
    for (int k = 0; k < 2; k++) begin
      step();
      vid_req = 1; wr_valid = 1; wr_addr = 15'(16'h3000 + k); wr_data = 8'(8'h50 + k);
    end
    for (int p = 0; p < 5; p++) begin
      step();
      wr_valid = 0;
      vid_req = (p == 0 || p == 2);
      vid_addr = 15'(8'h40 + p);
      @(negedge clk_25m);
      if (p >= 1) begin
        chk("prio_en", mem_en, 1);
        chk("prio_we", mem_we, (p % 2) == 0);
        chk("prio_addr", mem_addr, (p == 1) ? 16'h40 : (p == 2) ? 16'h3000 : (p == 3) ? 16'h42 : 16'h3001);
      end
      if (p == 4) chk("prio_level", wq_level, 0);
    end
    // simultaneous push and pop at occupancy 2
    for (int k = 0; k < 2; k++) begin
      step();
      vid_req = 1; wr_valid = 1; wr_addr = 15'(16'h4000 + k); wr_data = 8'(8'h60 + k);
    end
    for (int s = 0; s < 6; s++) begin
      step();
      vid_req = 0; wr_valid = s < 2; wr_addr = 15'(16'h4002 + s); wr_data = 8'(8'h62 + s);
      @(negedge clk_25m);
      if (s == 1 || s == 2) chk("sim_level", wq_level, 2);
      if (s >= 1 && s <= 4) begin
        chk("sim_we", mem_we, 1);
        chk("sim_addr", mem_addr, 16'h4000 + s - 1);
      end
    end
    // starvation: full queue blocked by scanout
    for (int k = 0; k < 4; k++) begin
      step();
      vid_req = 1; vid_addr = 15'($urandom_range(0, 31));
      wr_valid = 1; wr_addr = 15'(16'h5000 + k); wr_data = 8'($urandom_range(0, 255));
    end
    for (int k = 0; k <= LIMIT; k++) begin
      step();
      wr_valid = 0; vid_addr = 15'($urandom_range(0, 31));
      @(negedge clk_25m);
      if (k == LIMIT - 1) chk("starve_pre", wr_starved, 0);
      if (k == LIMIT) chk("starve_set", wr_starved, 1);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      vid_req = 0;
      @(negedge clk_25m);
      if (k == 9) begin
        chk("starve_sticky", wr_starved, 1);
        chk("starve_drained", wq_level, 0);
      end
    end
    // random traffic: active-line / blanking bursts, with a 5-cycle reset mid-traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      vid_req = $urandom_range(0, 99) < (((i % 80) < 55) ? 90 : 10);
      vid_addr = 15'($urandom_range(0, 31));
      wr_valid = $urandom_range(0, 99) < 60;
      wr_addr = 15'($urandom_range(0, 31));
      wr_data = 8'($urandom_range(0, 255));
      rst = (i >= 300 && i < 305);
      @(negedge clk_25m);
      if (i == 305) chk("rel2_ready_pre", wr_ready, 0);
      if (i == 306) begin
        chk("rel2_ready", wr_ready, 1);
        chk("rst_clears_starve", wr_starved, 0);
      end
    end
    step();
    vid_req = 0; wr_valid = 0;
    repeat (8) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
